ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL state: one clock; reset is asynchronous and active-low.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  asynchronous reset, active-low (0 = reset).
REQ-004 SHALL have port stall  input  6  pipeline stall vector; bit 2 = EX, bit 3 = MEM; 1 = Stop.
REQ-005 SHALL have port id_to_ex_bus  input  144  {pc[143:112], alu_op[111:108], src1[107:76], src2[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], store_data[31:0]}.
REQ-006 SHALL have port ex_to_mem_bus  output  76  {pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
REQ-007 SHALL have ports data_sram_en (1), data_sram_wen (4), data_sram_addr (32), data_sram_wdata (32), all outputs, driven from the latched instruction.
REQ-008 SHALL have forwarding outputs ex_we_o (1), ex_waddr_o (5), ex_wdata_o (32), and ex_is_load_o (1) = data_ram_en & sel_rf_res.
REQ-009 SHALL have output stallreq_for_ex (1): request to stall IF/ID/EX while the divider is running.

Function
REQ-010 Input register SHALL load id_to_ex_bus when stall[2]=0, load all-zero (bubble) when stall[2]=1 and stall[3]=0, and hold otherwise.
REQ-011 alu_op encoding SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU, 11 LUI, 12 DIV, 13 DIVU, 14 MFHI, 15 MFLO.
REQ-012 ADD/SUB SHALL wrap modulo 2^32 with no overflow trap.
REQ-013 Shifts SHALL use src1[4:0] as the shift amount and src2 as the value; LUI result = {src2[15:0], 16'h0}.
REQ-014 SLT/SLTU SHALL yield 32'h1 or 32'h0 (signed/unsigned compare of src1 < src2).
REQ-015 Loads/stores SHALL use ex_result = src1 + src2 as address; data_sram_addr = ex_result, data_sram_wdata = store_data, data_sram_en/wen = latched fields.
REQ-016 EX result and all forwarding/SRAM outputs SHALL be combinational from the input register (zero added latency); ex_to_mem_bus pass-through fields are copied unchanged.
REQ-017 Divider SHALL be radix-2 restoring, one quotient bit per cycle, with FSM states IDLE, BUSY, DONE.
REQ-018 IDLE -> BUSY SHALL occur on a clock edge where latched alu_op is DIV or DIVU; operands are captured (absolute values for DIV) and counter cleared.
REQ-019 BUSY SHALL iterate 32 cycles (counter 0..31); after iteration 31, FSM goes to DONE and HI <= remainder, LO <= quotient on that edge.
REQ-020 DIV signs: quotient negative iff operand signs differ; remainder takes dividend sign; 32'h80000000 / -1 yields LO = 32'h80000000, HI = 0.
REQ-021 Divide by zero SHALL complete in the same 33 cycles with LO = 32'hFFFFFFFF, HI = dividend.
REQ-022 stallreq_for_ex SHALL be 1 combinationally when (IDLE and latched op is DIV/DIVU) or BUSY; 0 in DONE — exactly 33 high cycles per divide.
REQ-023 DONE -> IDLE SHALL occur on the first edge with stall[2]=0; DIV/DIVU SHALL not restart while in DONE.
REQ-024 DIV/DIVU SHALL force rf_we = 0 on ex_to_mem_bus regardless of input.
REQ-025 MFHI/MFLO SHALL return current HI/LO; a MFHI/MFLO directly following a divide SHALL see the new value (divide writes HI/LO before releasing stall).

Reset
REQ-026 While rst=0: input register, HI, LO, counter SHALL be 0, FSM IDLE; hence ex_to_mem_bus, SRAM outputs, forwarding outputs and stallreq_for_ex all 0.
REQ-027 Reset asserted mid-divide SHALL abort immediately; HI/LO stay 0; no partial result is written.

Verification
REQ-028 ADD src1=32'h7FFFFFFF, src2=1, rf_we=1, waddr=8 -> next cycle ex_result = 32'h80000000, ex_we_o=1, ex_waddr_o=8.
REQ-029 DIV src1=-7, src2=2, stall[2] tied to stallreq_for_ex -> stallreq high 33 cycles, then LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; following MFLO returns 32'hFFFFFFFD.
REQ-030 DIVU src1=100, src2=0 -> after 33 cycles LO=32'hFFFFFFFF, HI=100; rf_we on bus = 0 throughout.
REQ-031 stall=6'b000100 with a valid instruction at input -> ex_to_mem_bus all zero next cycle; stall=6'b001100 -> register holds previous instruction.
REQ-032 Load with src1=32'h1000, src2=4, data_ram_en=1, sel_rf_res=1 -> data_sram_addr=32'h1004, ex_is_load_o=1.
REQ-033 rst driven low at BUSY cycle 10 of a DIVU -> outputs 0 asynchronously; after release FSM IDLE, HI=LO=0.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: ALU, load/store address, forwarding taps and a
// 32-cycle restoring divider with HI/LO.
// Ports: clk, rst (async active-low), stall[5:0], id_to_ex_bus[143:0] in;
//   ex_to_mem_bus[75:0], data_sram_*, ex_*_o forwarding, stallreq_for_ex out.
module ex_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   stall,
    input  logic [143:0] id_to_ex_bus,
    output logic [75:0]  ex_to_mem_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_wen,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    output logic         ex_we_o,
    output logic [4:0]   ex_waddr_o,
    output logic [31:0]  ex_wdata_o,
    output logic         ex_is_load_o,
    output logic         stallreq_for_ex
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;
    localparam logic [3:0] OP_LUI  = 4'd11;
    localparam logic [3:0] OP_DIV  = 4'd12;
    localparam logic [3:0] OP_DIVU = 4'd13;
    localparam logic [3:0] OP_MFHI = 4'd14;
    localparam logic [3:0] OP_MFLO = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } div_state_e;

    logic [143:0] id_ex_q, id_ex_d;
    div_state_e   state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [31:0]  rem_q, rem_d;
    logic [31:0]  quo_q, quo_d;
    logic [31:0]  dvs_q, dvs_d;
    logic         qneg_q, qneg_d;
    logic         rneg_q, rneg_d;
    logic         dz_q, dz_d;
    logic [31:0]  hi_q, hi_d;
    logic [31:0]  lo_q, lo_d;

    logic [31:0] pc, src1, src2, sdata, ex_result;
    logic [3:0]  alu_op, ram_wen;
    logic        ram_en, sel_res, rf_we, rf_we_eff, is_div;
    logic [4:0]  waddr, shamt;

    logic [32:0] shifted, diff;
    logic [31:0] step_rem, step_quo;

    logic unused_stall;
    assign unused_stall = ^{stall[5:4], stall[1:0]};

    assign pc      = id_ex_q[143:112];
    assign alu_op  = id_ex_q[111:108];
    assign src1    = id_ex_q[107:76];
    assign src2    = id_ex_q[75:44];
    assign ram_en  = id_ex_q[43];
    assign ram_wen = id_ex_q[42:39];
    assign sel_res = id_ex_q[38];
    assign rf_we   = id_ex_q[37];
    assign waddr   = id_ex_q[36:32];
    assign sdata   = id_ex_q[31:0];
    assign shamt   = src1[4:0];

    assign is_div    = (alu_op == OP_DIV) || (alu_op == OP_DIVU);
    assign rf_we_eff = rf_we & ~is_div;

    // Bubble only when MEM keeps moving; otherwise EX simply holds.
    always_comb begin
        id_ex_d = id_ex_q;
        if (!stall[2]) begin
            id_ex_d = id_to_ex_bus;
        end else if (!stall[3]) begin
            id_ex_d = '0;
        end
    end

    always_comb begin
        ex_result = 32'h0;
        case (alu_op)
            OP_ADD:  ex_result = src1 + src2;
            OP_SUB:  ex_result = src1 - src2;
            OP_AND:  ex_result = src1 & src2;
            OP_OR:   ex_result = src1 | src2;
            OP_XOR:  ex_result = src1 ^ src2;
            OP_NOR:  ex_result = ~(src1 | src2);
            OP_SLL:  ex_result = src2 << shamt;
            OP_SRL:  ex_result = src2 >> shamt;
            OP_SRA:  ex_result = $signed(src2) >>> shamt;
            OP_SLT:  ex_result = {31'h0, $signed(src1) < $signed(src2)};
            OP_SLTU: ex_result = {31'h0, src1 < src2};
            OP_LUI:  ex_result = {src2[15:0], 16'h0};
            OP_MFHI: ex_result = hi_q;
            OP_MFLO: ex_result = lo_q;
            default: ex_result = 32'h0;
        endcase
    end

    assign ex_to_mem_bus   = {pc, ram_en, ram_wen, sel_res, rf_we_eff,
                              waddr, ex_result};
    assign data_sram_en    = ram_en;
    assign data_sram_wen   = ram_wen;
    assign data_sram_addr  = ex_result;
    assign data_sram_wdata = sdata;
    assign ex_we_o         = rf_we_eff;
    assign ex_waddr_o      = waddr;
    assign ex_wdata_o      = ex_result;
    assign ex_is_load_o    = ram_en & sel_res;

    // One restoring step: shift in the next dividend bit from quo_q.
    // With a zero divisor every trial succeeds, giving all-ones and
    // the dividend as remainder.
    assign shifted  = {rem_q, quo_q[31]};
    assign diff     = shifted - {1'b0, dvs_q};
    assign step_rem = diff[32] ? shifted[31:0] : diff[31:0];
    assign step_quo = {quo_q[30:0], ~diff[32]};

    assign stallreq_for_ex = ((state_q == S_IDLE) && is_div) ||
                             (state_q == S_BUSY);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (is_div) begin
                    state_d = S_BUSY;
                    cnt_d   = 5'd0;
                    rem_d   = 32'h0;
                    qneg_d  = (alu_op == OP_DIV) & (src1[31] ^ src2[31]);
                    rneg_d  = (alu_op == OP_DIV) & src1[31];
                    dz_d    = (src2 == 32'h0);
                    quo_d   = ((alu_op == OP_DIV) && src1[31]) ?
                              32'h0 - src1 : src1;
                    dvs_d   = ((alu_op == OP_DIV) && src2[31]) ?
                              32'h0 - src2 : src2;
                end
            end
            S_BUSY: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                    hi_d    = rneg_q ? 32'h0 - step_rem : step_rem;
                    if (dz_q) begin
                        lo_d = 32'hFFFF_FFFF;
                    end else begin
                        lo_d = qneg_q ? 32'h0 - step_quo : step_quo;
                    end
                end
            end
            S_DONE: begin
                if (!stall[2]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_ex_q <= '0;
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            rem_q   <= 32'h0;
            quo_q   <= 32'h0;
            dvs_q   <= 32'h0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= 32'h0;
            lo_q    <= 32'h0;
        end else begin
            id_ex_q <= id_ex_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: ALU, memory address, stall,
// divider timing/results and reset abort.
module tb_ex_stage;

    logic         clk;
    logic         rst;
    logic [5:0]   stall;
    logic [5:0]   stall_man;
    logic         tie;
    logic         tie_mem;
    logic [143:0] id_bus;
    logic [75:0]  mem_bus;
    logic         sram_en;
    logic [3:0]   sram_wen;
    logic [31:0]  sram_addr;
    logic [31:0]  sram_wdata;
    logic         we_o;
    logic [4:0]   waddr_o;
    logic [31:0]  wdata_o;
    logic         is_load_o;
    logic         stallreq;

    int checks;
    int failures;

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_to_ex_bus    (id_bus),
        .ex_to_mem_bus   (mem_bus),
        .data_sram_en    (sram_en),
        .data_sram_wen   (sram_wen),
        .data_sram_addr  (sram_addr),
        .data_sram_wdata (sram_wdata),
        .ex_we_o         (we_o),
        .ex_waddr_o      (waddr_o),
        .ex_wdata_o      (wdata_o),
        .ex_is_load_o    (is_load_o),
        .stallreq_for_ex (stallreq)
    );

    assign stall = tie ? {2'b00, tie_mem & stallreq, stallreq,
                          stallreq, stallreq} : stall_man;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [143:0] mk(
        input logic [31:0] pc, input logic [3:0] op,
        input logic [31:0] s1, input logic [31:0] s2,
        input logic ren, input logic [3:0] wen, input logic sel,
        input logic we, input logic [4:0] wa, input logic [31:0] sd);
        mk = {pc, op, s1, s2, ren, wen, sel, we, wa, sd};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        id_bus = mk(32'h300, 4'd14, 0, 0, 0, 0, 0, 1, 5'd1, 0);
        step();
        hi = wdata_o;
        id_bus = mk(32'h304, 4'd15, 0, 0, 0, 0, 0, 1, 5'd2, 0);
        step();
        lo = wdata_o;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        id_bus = mk(32'hABC, 4'd12, 32'd9, 32'd3, 1, 4'hF, 1, 1, 5'd7, 32'h5);
        step();
        step();
        checks++;
        if (mem_bus !== 76'h0) begin
            failures++;
            $display("FAIL reset_bus got=%h exp=0", mem_bus);
        end
        checks++;
        if ({stallreq, we_o, is_load_o, sram_en, sram_addr} !== 36'h0) begin
            failures++;
            $display("FAIL reset_outs got=%h exp=0",
                     {stallreq, we_o, is_load_o, sram_en, sram_addr});
        end
        rst = 1'b1;
    endtask

    task automatic test_add();
        id_bus = mk(32'h100, 4'd0, 32'h7FFF_FFFF, 32'h1, 0, 0, 0, 1, 5'd8, 0);
        step();
        checks++;
        if (mem_bus !== {32'h100, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, 32'h8000_0000}) begin
            failures++;
            $display("FAIL add_bus got=%h", mem_bus);
        end
        checks++;
        if ({we_o, waddr_o, wdata_o} !== {1'b1, 5'd8, 32'h8000_0000}) begin
            failures++;
            $display("FAIL add_fwd got=%b/%0d/%h exp=1/8/80000000",
                     we_o, waddr_o, wdata_o);
        end
    endtask

    task automatic test_alu();
        logic [3:0]  ops [11];
        logic [31:0] a   [11];
        logic [31:0] b   [11];
        logic [31:0] e   [11];
        ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11};
        a = '{32'd5, 32'hF0F0, 32'hF0F0, 32'hFF, 32'h0, 32'h24, 32'h4,
              32'h4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        b = '{32'd7, 32'hFF00, 32'h0F0F, 32'h0F, 32'h0, 32'h1,
              32'h8000_0000, 32'h8000_0000, 32'h1, 32'h1, 32'h1234};
        e = '{32'hFFFF_FFFE, 32'hF000, 32'hFFFF, 32'hF0, 32'hFFFF_FFFF,
              32'h10, 32'h0800_0000, 32'hF800_0000, 32'h1, 32'h0,
              32'h1234_0000};
        for (int i = 0; i < 11; i++) begin
            id_bus = mk(32'h200, ops[i], a[i], b[i], 0, 0, 0, 1, 5'd3, 0);
            step();
            checks++;
            if (mem_bus[31:0] !== e[i]) begin
                failures++;
                $display("FAIL alu_op%0d got=%h exp=%h", ops[i],
                         mem_bus[31:0], e[i]);
            end
        end
    endtask

    task automatic test_mem();
        id_bus = mk(32'h400, 4'd0, 32'h1000, 32'h4, 1, 4'h0, 1, 1, 5'd3, 32'hDEAD);
        step();
        checks++;
        if ({sram_addr, is_load_o, sram_en} !== {32'h1004, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL load got=%h/%b/%b exp=1004/1/1",
                     sram_addr, is_load_o, sram_en);
        end
        id_bus = mk(32'h404, 4'd0, 32'h2000, 32'h10, 1, 4'hF, 0, 0, 5'd0,
                    32'hCAFE_BABE);
        step();
        checks++;
        if ({sram_addr, sram_wdata, sram_wen, is_load_o} !==
            {32'h2010, 32'hCAFE_BABE, 4'hF, 1'b0}) begin
            failures++;
            $display("FAIL store got=%h/%h/%h/%b", sram_addr, sram_wdata,
                     sram_wen, is_load_o);
        end
    endtask

    task automatic test_stall();
        logic [75:0] exp_a;
        logic [75:0] exp_b;
        exp_a = {32'h500, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 32'd30};
        exp_b = {32'h504, 1'b0, 4'h0, 1'b0, 1'b1, 5'd10, 32'd5};
        id_bus = mk(32'h500, 4'd0, 32'd10, 32'd20, 0, 0, 0, 1, 5'd9, 0);
        step();
        id_bus = mk(32'h504, 4'd1, 32'd8, 32'd3, 0, 0, 0, 1, 5'd10, 0);
        stall_man = 6'b000100;
        step();
        checks++;
        if (mem_bus !== 76'h0) begin
            failures++;
            $display("FAIL stall_bubble got=%h exp=0", mem_bus);
        end
        stall_man = 6'b000000;
        id_bus = mk(32'h500, 4'd0, 32'd10, 32'd20, 0, 0, 0, 1, 5'd9, 0);
        step();
        id_bus = mk(32'h504, 4'd1, 32'd8, 32'd3, 0, 0, 0, 1, 5'd10, 0);
        stall_man = 6'b001100;
        step();
        step();
        checks++;
        if (mem_bus !== exp_a) begin
            failures++;
            $display("FAIL stall_hold got=%h exp=%h", mem_bus, exp_a);
        end
        stall_man = 6'b000000;
        step();
        checks++;
        if (mem_bus !== exp_b) begin
            failures++;
            $display("FAIL stall_release got=%h exp=%h", mem_bus, exp_b);
        end
    endtask

    task automatic test_div();
        int n;
        tie = 1'b1;
        tie_mem = 1'b0;
        id_bus = mk(32'h600, 4'd12, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 1, 5'd4, 0);
        step();
        checks++;
        if ({stallreq, mem_bus[37]} !== 2'b10) begin
            failures++;
            $display("FAIL div_start got=stallreq %b rf_we %b exp=1 0",
                     stallreq, mem_bus[37]);
        end
        id_bus = mk(32'h604, 4'd15, 0, 0, 0, 0, 0, 1, 5'd5, 0);
        n = 0;
        while (stallreq && n < 100) begin
            n++;
            step();
        end
        checks++;
        if (n !== 33) begin
            failures++;
            $display("FAIL div_cycles got=%0d exp=33", n);
        end
        step();
        checks++;
        if (mem_bus[31:0] !== 32'hFFFF_FFFD) begin
            failures++;
            $display("FAIL div_mflo got=%h exp=FFFFFFFD", mem_bus[31:0]);
        end
        id_bus = mk(32'h608, 4'd14, 0, 0, 0, 0, 0, 1, 5'd6, 0);
        step();
        checks++;
        if (mem_bus[31:0] !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL div_mfhi got=%h exp=FFFFFFFF", mem_bus[31:0]);
        end
        tie = 1'b0;
    endtask

    task automatic test_divu_zero();
        int n;
        int we_bad;
        logic [31:0] hi;
        logic [31:0] lo;
        tie = 1'b1;
        tie_mem = 1'b1;
        id_bus = mk(32'h700, 4'd13, 32'd100, 32'd0, 0, 0, 0, 1, 5'd4, 0);
        step();
        id_bus = mk(32'h704, 4'd0, 0, 0, 0, 0, 0, 0, 5'd0, 0);
        n = 0;
        we_bad = 0;
        while (stallreq && n < 100) begin
            if (mem_bus[37] !== 1'b0) we_bad++;
            n++;
            step();
        end
        checks++;
        if (n !== 33 || we_bad !== 0) begin
            failures++;
            $display("FAIL divu_cycles got=%0d rf_we_hi=%0d exp=33 0", n, we_bad);
        end
        tie = 1'b0;
        stall_man = 6'b001100;
        step();
        step();
        checks++;
        if ({stallreq, mem_bus[37], mem_bus[75:44]} !== {2'b00, 32'h700}) begin
            failures++;
            $display("FAIL divu_no_restart got=%b/%b/%h exp=0/0/700",
                     stallreq, mem_bus[37], mem_bus[75:44]);
        end
        stall_man = 6'b000000;
        read_hilo(hi, lo);
        checks++;
        if ({hi, lo} !== {32'd100, 32'hFFFF_FFFF}) begin
            failures++;
            $display("FAIL divu_zero got=hi %h lo %h exp=hi 64 lo FFFFFFFF", hi, lo);
        end
    endtask

    task automatic test_div_ovf();
        int n;
        logic [31:0] hi;
        logic [31:0] lo;
        tie = 1'b1;
        tie_mem = 1'b0;
        id_bus = mk(32'h800, 4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 1,
                    5'd4, 0);
        step();
        id_bus = mk(32'h804, 4'd0, 0, 0, 0, 0, 0, 0, 5'd0, 0);
        n = 0;
        while (stallreq && n < 100) begin
            n++;
            step();
        end
        tie = 1'b0;
        read_hilo(hi, lo);
        checks++;
        if (n !== 33 || {hi, lo} !== {32'h0, 32'h8000_0000}) begin
            failures++;
            $display("FAIL div_ovf got=n %0d hi %h lo %h exp=33 0 80000000",
                     n, hi, lo);
        end
    endtask

    task automatic test_reset_mid_div();
        logic [31:0] hi;
        logic [31:0] lo;
        tie = 1'b1;
        tie_mem = 1'b1;
        id_bus = mk(32'h900, 4'd13, 32'd1000, 32'd7, 0, 0, 0, 1, 5'd4, 0);
        step();
        for (int i = 0; i < 11; i++) step();
        checks++;
        if (stallreq !== 1'b1) begin
            failures++;
            $display("FAIL rstdiv_busy got=%b exp=1", stallreq);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({stallreq, we_o, mem_bus} !== 78'h0) begin
            failures++;
            $display("FAIL rstdiv_async got=%b/%b/%h exp=0",
                     stallreq, we_o, mem_bus);
        end
        step();
        step();
        rst = 1'b1;
        tie = 1'b0;
        stall_man = 6'b000000;
        checks++;
        if (stallreq !== 1'b0) begin
            failures++;
            $display("FAIL rstdiv_idle got=%b exp=0", stallreq);
        end
        read_hilo(hi, lo);
        checks++;
        if ({hi, lo} !== 64'h0) begin
            failures++;
            $display("FAIL rstdiv_hilo got=hi %h lo %h exp=0", hi, lo);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        tie = 1'b0;
        tie_mem = 1'b0;
        stall_man = 6'b000000;
        rst = 1'b0;
        id_bus = '0;
        test_reset();
        test_add();
        test_alu();
        test_mem();
        test_stall();
        test_div();
        test_divu_zero();
        test_div_ovf();
        test_reset_mid_div();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
